lamp_driver: RTL and testbench

- Output-side companion to the traffic light controller: consumes the 4-bit light_signal code and drives the physical red/yellow/green lamps of the four lanes (NS1, NS2, EW1, EW2).
- Acts as an independent safety layer:
  - enforces an all-red clearance before any green;
  - enforces a minimum yellow time;
  - inserts a forced yellow when the controller skips one;
  - enters flashing-red fault mode on illegal codes.

---
 rtl/lamp_driver.sv | 201 ++++++++++++++++++++
 tb/tb_lamp_driver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lamp_driver.sv
// lamp_driver: safety layer between the light controller and the lamps.
// Forces all-red clearance, minimum yellow, and flashing-red fault mode.
module lamp_driver #(
  parameter int CLEAR_CYC  = 4,
  parameter int MIN_YELLOW = 3,
  parameter int FLASH_CYC  = 8,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] light_signal,
  output logic [2:0] lamp_ns1,
  output logic [2:0] lamp_ns2,
  output logic [2:0] lamp_ew1,
  output logic [2:0] lamp_ew2,
  output logic       fault,
  output logic       seq_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_RED,
    S_GREEN,
    S_YELLOW,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CLR      = CNT_W'(CLEAR_CYC);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(MIN_YELLOW - 1);
  localparam logic [CNT_W-1:0] FL_LAST  = CNT_W'(FLASH_CYC - 1);
  localparam logic [11:0]      ALL_RED  = {4{3'b100}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] ok_q, ok_d;
  logic [CNT_W-1:0] ok_inc;
  logic [1:0]       lane_q, lane_d;
  logic             flash_q, flash_d;
  logic             seq_d;
  logic [11:0]      lamps_q, lamps_d;
  logic             fault_q;
  logic             seq_q;

  logic             illegal;
  logic             is_green;
  logic [1:0]       code_lane;
  logic [3:0]       my_g;
  logic [3:0]       my_y;
  logic [3:0]       disp_code;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [11:0] lamp_map(
    input state_t     s,
    input logic [1:0] l,
    input logic       f
  );
    logic [11:0] r;
    r = ALL_RED;
    unique case (s)
      S_GREEN: begin
        for (int i = 0; i < 4; i++)
          if (2'(i) == l) r[11-3*i -: 3] = 3'b001;
      end
      S_YELLOW: begin
        for (int i = 0; i < 4; i++)
          if (2'(i) == l) r[11-3*i -: 3] = 3'b010;
      end
      S_FAULT: r = {4{f, 2'b00}};
      default: r = ALL_RED;
    endcase
    return r;
  endfunction

  always_comb begin
    illegal   = (light_signal >= 4'd9);
    is_green  = !illegal && light_signal[0];
    code_lane = 2'((light_signal - 4'd1) >> 1);
    my_g      = {1'b0, lane_q, 1'b1};
    my_y      = {1'b0, lane_q, 1'b0} + 4'd2;
    ok_inc    = sat_inc(ok_q);
  end

  always_comb begin
    disp_code = 4'd0;
    unique case (state_q)
      S_GREEN:  disp_code = my_g;
      S_YELLOW: disp_code = my_y;
      default:  disp_code = 4'd0;
    endcase
  end

  assign busy = (disp_code != light_signal);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    lane_d  = lane_q;
    flash_d = flash_q;
    fcnt_d  = fcnt_q;
    ok_d    = ok_q;
    seq_d   = 1'b0;
    // Illegal codes win from any state; in fault they just clear ok.
    if (illegal && state_q != S_FAULT) begin
      state_d = S_FAULT;
      timer_d = '0;
      flash_d = 1'b1;
      fcnt_d  = '0;
      ok_d    = '0;
    end else begin
      unique case (state_q)
        S_RED: begin
          if (is_green && timer_q >= CLR) begin
            state_d = S_GREEN;
            lane_d  = code_lane;
            timer_d = '0;
          end else begin
            timer_d = sat_inc(timer_q);
          end
        end
        S_GREEN: begin
          if (light_signal == my_y) begin
            state_d = S_YELLOW;
            timer_d = '0;
          end else if (light_signal != my_g) begin
            state_d = S_YELLOW;
            timer_d = '0;
            seq_d   = 1'b1;
          end
        end
        S_YELLOW: begin
          if (timer_q >= YEL_LAST && light_signal != my_y) begin
            state_d = S_RED;
            timer_d = '0;
          end else begin
            timer_d = sat_inc(timer_q);
          end
        end
        S_FAULT: begin
          if (fcnt_q >= FL_LAST) begin
            flash_d = ~flash_q;
            fcnt_d  = '0;
          end else begin
            fcnt_d = sat_inc(fcnt_q);
          end
          if (light_signal == 4'd0) begin
            ok_d = ok_inc;
            if (ok_inc >= CLR) begin
              state_d = S_RED;
              timer_d = '0;
              ok_d    = '0;
            end
          end else begin
            ok_d = '0;
          end
        end
        default: state_d = S_RED;
      endcase
    end
  end

  assign lamps_d = lamp_map(state_d, lane_d, flash_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RED;
      timer_q <= '0;
      fcnt_q  <= '0;
      ok_q    <= '0;
      lane_q  <= 2'd0;
      flash_q <= 1'b1;
      lamps_q <= ALL_RED;
      fault_q <= 1'b0;
      seq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fcnt_q  <= fcnt_d;
      ok_q    <= ok_d;
      lane_q  <= lane_d;
      flash_q <= flash_d;
      lamps_q <= lamps_d;
      fault_q <= (state_d == S_FAULT);
      seq_q   <= seq_d;
    end
  end

  assign lamp_ns1 = lamps_q[11:9];
  assign lamp_ns2 = lamps_q[8:6];
  assign lamp_ew1 = lamps_q[5:3];
  assign lamp_ew2 = lamps_q[2:0];
  assign fault    = fault_q;
  assign seq_err  = seq_q;

endmodule

// File: tb/tb_lamp_driver.sv
// tb_lamp_driver: directed vectors with a queue-based scoreboard.
// Stimulus pushes expected outputs; a monitor pops and compares.
module tb_lamp_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] light_signal = 4'd1;
  logic [2:0] lamp_ns1, lamp_ns2, lamp_ew1, lamp_ew2;
  logic       fault, seq_err, busy;

  lamp_driver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .light_signal (light_signal),
    .lamp_ns1     (lamp_ns1),
    .lamp_ns2     (lamp_ns2),
    .lamp_ew1     (lamp_ew1),
    .lamp_ew2     (lamp_ew2),
    .fault        (fault),
    .seq_err      (seq_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] lamps;
    logic        flt;
    logic        seq;
    logic        bsy;
  } exp_t;

  localparam logic [11:0] RED  = 12'b100_100_100_100;
  localparam logic [11:0] DARK = 12'b000_000_000_000;
  localparam logic [2:0]  G    = 3'b001;
  localparam logic [2:0]  Y    = 3'b010;

  exp_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;
  int   idx    = 0;

  function automatic logic [11:0] one(input int lane, input logic [2:0] v);
    logic [11:0] r;
    r = RED;
    r[11-3*lane -: 3] = v;
    return r;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.lamps = {lamp_ns1, lamp_ns2, lamp_ew1, lamp_ew2};
    a.flt   = fault;
    a.seq   = seq_err;
    a.bsy   = busy;
    return a;
  endfunction

  task automatic chk(input string name, input exp_t e, input exp_t a);
    n_run++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got lamps=%b fault=%b seq_err=%b busy=%b, want lamps=%b fault=%b seq_err=%b busy=%b",
               name, a.lamps, a.flt, a.seq, a.bsy,
               e.lamps, e.flt, e.seq, e.bsy);
    end
  endtask

  task automatic step(input logic [3:0] c, input logic [11:0] l,
                      input logic f, input logic s, input logic b);
    exp_t e;
    e.lamps = l;
    e.flt   = f;
    e.seq   = s;
    e.bsy   = b;
    light_signal = c;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk($sformatf("step%0d", idx), e, sample());
        idx++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t r;
    r.lamps = RED;
    r.flt   = 1'b0;
    r.seq   = 1'b0;
    r.bsy   = 1'b1;

    light_signal = 4'd1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset", r, sample());
    rst_n = 1'b1;

    // 1: clearance after reset
    repeat (4) step(1, RED, 0, 0, 1);
    step(1, one(0, G), 0, 0, 0);
    step(1, one(0, G), 0, 0, 0);

    // 2: proper yellow then NS2
    step(2, one(0, Y), 0, 0, 0);
    step(3, one(0, Y), 0, 0, 1);
    step(3, one(0, Y), 0, 0, 1);
    step(3, RED, 0, 0, 1);
    repeat (4) step(3, RED, 0, 0, 1);
    step(3, one(1, G), 0, 0, 0);

    // 3: skipped yellow, then held yellow code
    step(5, one(1, Y), 0, 1, 1);
    step(5, one(1, Y), 0, 0, 1);
    step(5, one(1, Y), 0, 0, 1);
    step(5, RED, 0, 0, 1);
    repeat (4) step(5, RED, 0, 0, 1);
    step(5, one(2, G), 0, 0, 0);
    repeat (4) step(6, one(2, Y), 0, 0, 0);
    step(5, RED, 0, 0, 1);
    repeat (4) step(7, RED, 0, 0, 1);
    step(7, one(3, G), 0, 0, 0);

    // 4: fault, flash, recovery
    repeat (8) step(9, RED, 1, 0, 1);
    repeat (8) step(9, DARK, 1, 0, 1);
    repeat (3) step(0, RED, 1, 0, 0);
    step(1, RED, 1, 0, 1);
    repeat (3) step(0, RED, 1, 0, 0);
    step(0, RED, 0, 0, 0);
    repeat (4) step(1, RED, 0, 0, 1);
    step(1, one(0, G), 0, 0, 0);

    // 5: yellow code in expired red is ignored
    step(2, one(0, Y), 0, 0, 0);
    step(0, one(0, Y), 0, 0, 1);
    step(0, one(0, Y), 0, 0, 1);
    step(0, RED, 0, 0, 0);
    repeat (5) step(0, RED, 0, 0, 0);
    step(4, RED, 0, 0, 1);
    step(4, RED, 0, 0, 1);
    step(3, one(1, G), 0, 0, 0);

    // 6: async reset mid-yellow
    step(4, one(1, Y), 0, 0, 0);
    step(4, one(1, Y), 0, 0, 0);
    light_signal = 4'd1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", r, sample());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(1, RED, 0, 0, 1);
    step(1, one(0, G), 0, 0, 0);
    step(0, one(0, Y), 0, 1, 1);
    step(0, one(0, Y), 0, 0, 1);

    repeat (3) begin
      if (q.size() != 0) @(negedge clk);
    end
    n_run++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
